// File: rtl/tick_sched_pkg.sv
// Shared types and limits for the tick-driven shared countdown scheduler.
package tick_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int NREQ_MIN = 2;
  localparam int NREQ_MAX = 8;

  function automatic bit nreq_ok(input int n);
    return (n >= NREQ_MIN) && (n <= NREQ_MAX);
  endfunction

endpackage

// File: rtl/tick_sched_rr_pick.sv
// Combinational round-robin picker: first set req searching upward from last+1.
module rr_pick
  import tick_sched_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] sel,
  output logic [IW-1:0]   idx
);

  logic          found;
  logic [IW-1:0] j;

  always_comb begin
    sel   = '0;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      j = IW'((int'(last) + k) % NREQ);
      if (!found && req[j]) begin
        found  = 1'b1;
        sel[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/tick_sched.sv
// One countdown timer shared by NREQ requesters; round-robin grant, tick-driven
// countdown, one-clk done pulse to the winner.
module tick_sched
  import tick_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int CNTW = 8,
  localparam int IW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 tick,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*CNTW-1:0] len,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic                 busy,
  output logic [CNTW-1:0]      cnt
);

  generate
    if (!nreq_ok(NREQ)) begin : g_bad_nreq
      $error("tick_sched: NREQ out of range");
    end
  endgenerate

  logic [NREQ-1:0][CNTW-1:0] len_a;
  assign len_a = len;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_d, done_d;
  logic            busy_d;
  logic [CNTW-1:0] cnt_d;
  // last_q doubles as the current winner's index once granted
  logic [IW-1:0]   last_q, last_d;

  logic [NREQ-1:0] pick_sel;
  logic [IW-1:0]   pick_idx;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req  (req),
    .last (last_q),
    .sel  (pick_sel),
    .idx  (pick_idx)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      gnt     <= '0;
      done    <= '0;
      busy    <= 1'b0;
      cnt     <= '0;
      last_q  <= IW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      gnt     <= gnt_d;
      done    <= done_d;
      busy    <= busy_d;
      cnt     <= cnt_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt;
    done_d  = '0;
    busy_d  = busy;
    cnt_d   = cnt;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          gnt_d   = pick_sel;
          last_d  = pick_idx;
          cnt_d   = len_a[pick_idx];
          busy_d  = 1'b1;
          state_d = (len_a[pick_idx] != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        // abort wins over a coincident tick
        if (!req[last_q]) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else if (tick) begin
          if (cnt > CNTW'(1)) begin
            cnt_d = cnt - CNTW'(1);
          end else begin
            cnt_d   = '0;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        done_d  = gnt;
        gnt_d   = '0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule
